// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
//   Sequencer between a CPU load/store port, a small registered-lookup cache
//   and a backing memory. Requests are served one at a time:
//     read hit  : LOOKUP -> CHECK -> RESP
//     read miss : LOOKUP -> CHECK -> MEM_RD -> FILL -> RESP
//     write     : MEM_WR -> FILL -> RESP  (write-through, then install)
//   Saturating hit/miss counters count reads only.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/ready     CPU request handshake (ready only in IDLE)
//   req_we/addr/wdata   CPU request fields, latched on accept
//   resp_valid/rdata    one-cycle completion pulse and read data
//   c_we/addr/wdata     cache lookup / install port
//   c_rdata/c_hit       cache lookup result, registered inside the cache
//   mem_req/we/addr/    memory request, held until mem_ack
//   mem_wdata
//   mem_rdata/mem_ack   memory completion (one-cycle ack) and read data
//   hit_cnt/miss_cnt    saturating read hit / miss counters
// -----------------------------------------------------------------------------
module cache_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  c_we,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [DATA_WIDTH-1:0] c_wdata,
    input  logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  c_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_RD,
        MEM_WR,
        FILL,
        RESP
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                next_state;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: every branch of a combinational block must assign its outputs;
    // assigning the default first means no path can leave next_state unassigned
    // and infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (req_valid) next_state = req_we ? MEM_WR : LOOKUP;
            LOOKUP:  next_state = CHECK;
            CHECK:   next_state = c_hit ? RESP : MEM_RD;
            MEM_RD:  if (mem_ack) next_state = FILL;
            MEM_WR:  if (mem_ack) next_state = FILL;
            FILL:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == CHECK) begin
                if (c_hit) begin
                    rdata_q <= c_rdata;
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_ONE;
                end else if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + CNT_ONE;
                end
            end
            if (state == MEM_RD && mem_ack) rdata_q <= mem_rdata;
        end
    end

    // Outputs are registered from next_state so they line up exactly with the
    // state they belong to. Values needed on the same edge that latches
    // addr_q/rdata_q are taken from the source directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            c_we       <= 1'b0;
            c_addr     <= '0;
            c_wdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            req_ready  <= (next_state == IDLE);
            resp_valid <= (next_state == RESP);
            c_we       <= (next_state == FILL);
            mem_req    <= (next_state == MEM_RD) || (next_state == MEM_WR);
            mem_we     <= (next_state == MEM_WR);

            if (state == IDLE && next_state == LOOKUP) c_addr <= req_addr;
            if (state == IDLE && next_state == MEM_WR) begin
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
            if (state == CHECK && next_state == MEM_RD) mem_addr <= addr_q;
            if (next_state == FILL) begin
                c_addr  <= addr_q;
                c_wdata <= we_q ? wdata_q : mem_rdata;
            end
            if (next_state == RESP) resp_rdata <= (state == CHECK) ? c_rdata : rdata_q;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
//   Two cache_ctrl instances (CNT_WIDTH 16 and 2) share one stimulus stream.
//   The bench models the cache and memory environment, predicts each request's
//   outcome from a flat reference view of memory, and checks responses from a
//   scoreboard queue in a separate monitor.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic [7:0] c_rdata = '0;
    logic       c_hit = 1'b0;
    logic [7:0] mem_rdata = '0;
    logic       mem_ack = 1'b0;

    logic        req_ready, resp_valid, c_we, mem_req, mem_we;
    logic [7:0]  resp_rdata, c_addr, c_wdata, mem_addr, mem_wdata;
    logic [15:0] hit_cnt, miss_cnt;

    logic        req_ready_s, resp_valid_s, c_we_s, mem_req_s, mem_we_s;
    logic [7:0]  resp_rdata_s, c_addr_s, c_wdata_s, mem_addr_s, mem_wdata_s;
    logic [1:0]  hit_cnt_s, miss_cnt_s;

    always #5 clk = ~clk;

    cache_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_hit(c_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_s), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_s), .resp_rdata(resp_rdata_s),
        .c_we(c_we_s), .c_addr(c_addr_s), .c_wdata(c_wdata_s),
        .c_rdata(c_rdata), .c_hit(c_hit),
        .mem_req(mem_req_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt_s), .miss_cnt(miss_cnt_s)
    );

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        bit         hit;
        int         hits;
        int         misses;
        int         acc_cyc;
        int         waits;
        int         mem_cycles;
        int         fills;
    } txn_t;

    txn_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference view: what memory holds and which lines have ever been installed.
    logic [7:0] ref_mem [256];
    bit         ref_valid [256];
    int         ref_hits = 0;
    int         ref_misses = 0;

    // Environment: backing memory and cache contents.
    logic [7:0] mem_arr [256];
    bit         cvalid [256];
    logic [7:0] cdata [256];
    int         force_wait = -1;
    bit         stray_all = 1'b0;
    bit         in_req = 1'b0;
    int         wcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check2(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        check(name, a, exp);
        check({name, "_sat"}, b, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor, cache model and memory model, all evaluated on the falling edge.
    initial begin
        txn_t t;
        int   exp_lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                check2("req_ready", 32'(req_ready), 32'(req_ready_s), 32'(exp_q.size() == 0));
                if (exp_q.size() > 0) begin
                    if (mem_req) begin
                        exp_q[0].mem_cycles = exp_q[0].mem_cycles + 1;
                        if (exp_q[0].hit) fail_now("mem_req_on_hit");
                        check("mem_req_sat", 32'(mem_req_s), 32'd1);
                        check2("mem_addr", 32'(mem_addr), 32'(mem_addr_s), 32'(exp_q[0].addr));
                        check2("mem_we", 32'(mem_we), 32'(mem_we_s), 32'(exp_q[0].we));
                        if (exp_q[0].we)
                            check2("mem_wdata", 32'(mem_wdata), 32'(mem_wdata_s), 32'(exp_q[0].data));
                    end
                    if (c_we) begin
                        exp_q[0].fills = exp_q[0].fills + 1;
                        check("c_we_sat", 32'(c_we_s), 32'd1);
                        check2("fill_addr", 32'(c_addr), 32'(c_addr_s), 32'(exp_q[0].addr));
                        check2("fill_data", 32'(c_wdata), 32'(c_wdata_s), 32'(exp_q[0].data));
                    end
                end else if (mem_req || c_we) begin
                    fail_now("activity_while_idle");
                end
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_resp");
                    end else begin
                        t = exp_q.pop_front();
                        exp_lat = t.hit ? 3 : (t.we ? 3 + t.waits : 5 + t.waits);
                        check("latency", 32'(cyc - t.acc_cyc), 32'(exp_lat));
                        check("resp_valid_sat", 32'(resp_valid_s), 32'd1);
                        if (!t.we)
                            check2("resp_rdata", 32'(resp_rdata), 32'(resp_rdata_s), 32'(t.data));
                        check("mem_cycles", 32'(t.mem_cycles), 32'(t.hit ? 0 : t.waits + 1));
                        check("fill_count", 32'(t.fills), 32'(t.hit ? 0 : 1));
                        check("hit_cnt", 32'(hit_cnt), 32'(t.hits));
                        check("miss_cnt", 32'(miss_cnt), 32'(t.misses));
                        check("hit_cnt_sat", 32'(hit_cnt_s), 32'(t.hits > 3 ? 3 : t.hits));
                        check("miss_cnt_sat", 32'(miss_cnt_s), 32'(t.misses > 3 ? 3 : t.misses));
                    end
                end
            end

            // Memory: ack after wcnt extra cycles; stray acks while no request.
            mem_ack = 1'b0;
            if (!rst) begin
                in_req = 1'b0;
            end else if (mem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wcnt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                    if (exp_q.size() > 0) exp_q[0].waits = wcnt;
                end
                if (wcnt == 0) begin
                    mem_ack = 1'b1;
                    in_req = 1'b0;
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    else mem_rdata = mem_arr[mem_addr];
                end else begin
                    wcnt--;
                end
            end else if (stray_all || $urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
                mem_rdata = 8'($urandom);
            end

            // Cache: lookup result registered from the presented address.
            c_hit = cvalid[c_addr];
            c_rdata = cdata[c_addr];
            if (rst && c_we) begin
                cvalid[c_addr] = 1'b1;
                cdata[c_addr] = c_wdata;
            end
        end
    end

    // Build the expected outcome of one request from the reference view.
    task automatic predict(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           output txn_t t);
        t.we = we;
        t.addr = addr;
        t.hit = 1'b0;
        if (we) begin
            ref_mem[addr] = wdata;
            t.data = wdata;
        end else begin
            t.hit = ref_valid[addr];
            t.data = ref_mem[addr];
            if (t.hit) ref_hits++;
            else ref_misses++;
        end
        ref_valid[addr] = 1'b1;
        t.hits = ref_hits;
        t.misses = ref_misses;
        t.acc_cyc = cyc;
        t.waits = 0;
        t.mem_cycles = 0;
        t.fills = 0;
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
    endtask

    // Issue one request and wait for it to retire. With hold set, req_valid
    // stays high with junk fields while the controller is busy.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input int waits, input bit hold, output int ready_wait);
        txn_t t;
        int   guard;
        wait_ready(ready_wait);
        if (!req_ready) begin
            fail_now("ready_timeout");
            return;
        end
        predict(we, addr, wdata, t);
        force_wait = waits;
        exp_q.push_back(t);
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        @(negedge clk); #1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            if (hold) begin
                req_valid = 1'b1;
                req_we = 1'($urandom);
                req_addr = 8'($urandom);
                req_wdata = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            fail_now("resp_timeout");
            exp_q.delete();
        end
    endtask

    task automatic reset_mid_read();
        txn_t t;
        int   waited;
        wait_ready(waited);
        predict(1'b0, 8'hF0, 8'h00, t);
        force_wait = 20;
        exp_q.push_back(t);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 8'hF0;
        @(negedge clk); #1;
        req_valid = 1'b0;
        waited = 0;
        while (!mem_req && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        check("t5_in_mem_rd", 32'(mem_req), 32'd1);
        #1 rst = 1'b0;
        #1;
        check2("t5_mem_req", 32'(mem_req), 32'(mem_req_s), 32'd0);
        check2("t5_resp_valid", 32'(resp_valid), 32'(resp_valid_s), 32'd0);
        check2("t5_req_ready", 32'(req_ready), 32'(req_ready_s), 32'd1);
        check2("t5_hit_cnt", 32'(hit_cnt), 32'(hit_cnt_s), 32'd0);
        check2("t5_miss_cnt", 32'(miss_cnt), 32'(miss_cnt_s), 32'd0);
        exp_q.delete();
        ref_hits = 0;
        ref_misses = 0;
        ref_valid[8'hF0] = 1'b0;
        force_wait = -1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        // The monitor flags any resp_valid appearing in these idle cycles.
        repeat (6) @(negedge clk);
        #1;
    endtask

    initial begin
        int rw;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 8'($urandom);
            ref_mem[i] = mem_arr[i];
            cvalid[i] = 1'b0;
            cdata[i] = '0;
            ref_valid[i] = 1'b0;
        end
        #1 rst = 1'b0;
        #2;
        check2("rst_req_ready", 32'(req_ready), 32'(req_ready_s), 32'd1);
        check2("rst_resp_valid", 32'(resp_valid), 32'(resp_valid_s), 32'd0);
        check2("rst_mem_req", 32'(mem_req), 32'(mem_req_s), 32'd0);
        check2("rst_c_we", 32'(c_we), 32'(c_we_s), 32'd0);
        check2("rst_hit_cnt", 32'(hit_cnt), 32'(hit_cnt_s), 32'd0);
        check2("rst_miss_cnt", 32'(miss_cnt), 32'(miss_cnt_s), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;

        // Cold read miss with two wait cycles, then repeated hits.
        mem_arr[8'h12] = 8'hA5;
        ref_mem[8'h12] = 8'hA5;
        issue(1'b0, 8'h12, 8'h00, 2, 1'b0, rw);
        for (int i = 0; i < 5; i++) issue(1'b0, 8'h12, 8'h00, -1, 1'b0, rw);

        // Write-through with immediate ack.
        issue(1'b1, 8'h34, 8'h5C, 0, 1'b0, rw);

        // req_valid held high across a miss, stray acks whenever no request.
        stray_all = 1'b1;
        issue(1'b0, 8'h20, 8'h00, 1, 1'b1, rw);
        issue(1'b0, 8'h20, 8'h00, -1, 1'b1, rw);
        check("t4_ready_after_resp", 32'(rw), 32'd1);
        stray_all = 1'b0;
        req_valid = 1'b0;

        for (int n = 0; n < 250; n++)
            issue(1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 47)), 8'($urandom),
                  -1, 1'($urandom), rw);

        reset_mid_read();

        for (int n = 0; n < 60; n++)
            issue(1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 47)), 8'($urandom),
                  -1, 1'($urandom), rw);

        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
